menu_nav_ctl: RTL



---
 rtl/menu_pkg.sv | 26 ++
 rtl/menu_nav_ctl_btn_repeat.sv | 55 +++++
 rtl/menu_nav_ctl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/menu_pkg.sv
// Shared definitions for the menu navigation controller: state encoding,
// menu item indices and the foreground/background colour palette.
package menu_pkg;

   typedef enum logic [1:0] {
      ST_MENU    = 2'd0,
      ST_GAME    = 2'd1,
      ST_RELEASE = 2'd2
   } menu_state_t;

   localparam logic [1:0] ITEM_START  = 2'd0;
   localparam logic [1:0] ITEM_DIFF   = 2'd1;
   localparam logic [1:0] ITEM_COLORS = 2'd2;

   // Returns {color1, color2} for a palette index
   function automatic logic [23:0] palette(input logic [1:0] idx);
      case (idx)
         2'd0:    palette = {12'hFFF, 12'h000};
         2'd1:    palette = {12'hF00, 12'h00F};
         2'd2:    palette = {12'h0F0, 12'hF0F};
         2'd3:    palette = {12'hFF0, 12'h0FF};
         default: palette = {12'hFFF, 12'h000};
      endcase
   endfunction

endpackage

// File: rtl/menu_nav_ctl_btn_repeat.sv
// Button front end: input register, press-edge detection and auto-repeat.
// Emits a registered one-cycle step on each press edge and every REPEAT_CYCLES of hold.
module btn_repeat #(
   parameter int REPEAT_CYCLES = 16_250_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic block,
   output logic btn_q,
   output logic step
);

   localparam int CNT_W = $clog2(REPEAT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic             step_s;

   // Next counter value and step decision; opposing button held suppresses everything
   always_comb begin
      cnt_s  = cnt_r;
      step_s = 1'b0;
      if (btn & block) begin
         cnt_s = '0;
      end else if (btn & ~btn_q) begin
         step_s = 1'b1;
         cnt_s  = '0;
      end else if (btn) begin
         if (cnt_r == CNT_LAST) begin
            step_s = 1'b1;
            cnt_s  = '0;
         end else begin
            cnt_s = cnt_r + CNT_W'(1);
         end
      end else begin
         cnt_s = '0;
      end
   end

   // Input register, repeat counter and registered step pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_q <= 1'b0;
         cnt_r <= '0;
         step  <= 1'b0;
      end else begin
         btn_q <= btn;
         cnt_r <= cnt_s;
         step  <= step_s;
      end
   end

endmodule

// File: rtl/menu_nav_ctl.sv
// Menu navigation controller: cursor, difficulty and palette selection, hand-off
// to the game on START; configuration outputs only change at frame boundaries.
module menu_nav_ctl
   import menu_pkg::*;
#(
   parameter int REPEAT_CYCLES = 16_250_000,
   parameter int N_ITEMS       = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_enter,
   input  logic        vsync_in,
   input  logic        game_over,
   output logic [1:0]  sel_item,
   output logic        difficulty,
   output logic [11:0] color1,
   output logic [11:0] color2,
   output logic        game_start,
   output logic        in_game
);

   localparam logic [1:0] ITEM_MAX = 2'(N_ITEMS - 1);

   menu_state_t state_r;
   menu_state_t state_s;
   logic        up_q;
   logic        down_q;
   logic        up_step;
   logic        down_step;
   logic        enter_q;
   logic        enter_evt_r;
   logic        vsync_q;
   logic        vsync_evt_r;
   logic        diff_pend_r;
   logic        diff_pend_s;
   logic [1:0]  pal_pend_r;
   logic [1:0]  pal_pend_s;
   logic [1:0]  sel_s;
   logic        game_start_s;
   logic        in_game_s;

   btn_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_up (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_up),
      .block (btn_down),
      .btn_q (up_q),
      .step  (up_step)
   );

   btn_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_down (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_down),
      .block (btn_up),
      .btn_q (down_q),
      .step  (down_step)
   );

   // Enter and vsync are registered, then their rising edges are registered as events
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enter_q     <= 1'b0;
         enter_evt_r <= 1'b0;
         vsync_q     <= 1'b0;
         vsync_evt_r <= 1'b0;
      end else begin
         enter_q     <= btn_enter;
         enter_evt_r <= btn_enter & ~enter_q;
         vsync_q     <= vsync_in;
         vsync_evt_r <= vsync_in & ~vsync_q;
      end
   end

   // Next-state and next-output logic; enter takes precedence over cursor steps
   always_comb begin
      state_s      = state_r;
      sel_s        = sel_item;
      diff_pend_s  = diff_pend_r;
      pal_pend_s   = pal_pend_r;
      game_start_s = 1'b0;
      in_game_s    = in_game;
      case (state_r)
         ST_MENU: begin
            if (enter_evt_r) begin
               case (sel_item)
                  ITEM_START: begin
                     game_start_s = 1'b1;
                     in_game_s    = 1'b1;
                     state_s      = ST_GAME;
                  end
                  ITEM_DIFF: begin
                     diff_pend_s = ~diff_pend_r;
                     state_s     = ST_RELEASE;
                  end
                  ITEM_COLORS: begin
                     pal_pend_s = pal_pend_r + 2'd1;
                     state_s    = ST_RELEASE;
                  end
                  default: begin
                     state_s = ST_MENU;
                  end
               endcase
            end else if (down_step & ~up_step) begin
               sel_s = (sel_item >= ITEM_MAX) ? 2'd0 : sel_item + 2'd1;
            end else if (up_step & ~down_step) begin
               sel_s = (sel_item == 2'd0) ? ITEM_MAX : sel_item - 2'd1;
            end else begin
               sel_s = sel_item;
            end
         end
         ST_GAME: begin
            if (game_over) begin
               state_s   = ST_RELEASE;
               sel_s     = ITEM_START;
               in_game_s = 1'b0;
            end else begin
               state_s = ST_GAME;
            end
         end
         ST_RELEASE: begin
            if (~(up_q | down_q | enter_q)) begin
               state_s = ST_MENU;
            end else begin
               state_s = ST_RELEASE;
            end
         end
         default: begin
            state_s = ST_MENU;
         end
      endcase
   end

   // State register and registered control outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_MENU;
         sel_item    <= 2'd0;
         diff_pend_r <= 1'b0;
         pal_pend_r  <= 2'd0;
         game_start  <= 1'b0;
         in_game     <= 1'b0;
      end else begin
         state_r     <= state_s;
         sel_item    <= sel_s;
         diff_pend_r <= diff_pend_s;
         pal_pend_r  <= pal_pend_s;
         game_start  <= game_start_s;
         in_game     <= in_game_s;
      end
   end

   // Pending configuration is published only on a frame boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         difficulty <= 1'b0;
         color1     <= 12'hFFF;
         color2     <= 12'h000;
      end else if (vsync_evt_r) begin
         difficulty       <= diff_pend_r;
         {color1, color2} <= palette(pal_pend_r);
      end
   end

endmodule
